// File: rtl/fir3_pkg.sv
// Shared types and widths for the 3-lane FIR output path.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fir3_pkg;

    localparam int LANES = 3;
    localparam int OUT_W = 16;
    localparam int ACC_W = 32;

    typedef logic signed [OUT_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef sample_t                 block_t [LANES];

endpackage

// File: rtl/fir3_round_sat.sv
// Rounds one 32-bit FIR lane result by SHIFT (half up) and saturates it to 16 bits.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is used.
module fir3_round_sat
    import fir3_pkg::*;
#(
    parameter int SHIFT = 15
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    clamped
);

    localparam acc_t HALF  = acc_t'(32'd1 << (SHIFT - 1));
    localparam acc_t MAX_S = acc_t'((2 ** (OUT_W - 1)) - 1);
    localparam acc_t MIN_S = -acc_t'(2 ** (OUT_W - 1));

    // The rounding add wraps in 32 bits on purpose: this matches the FIR's own accumulator width.
    acc_t sum;
    acc_t shr;

    assign sum = acc_in + HALF;
    assign shr = sum >>> SHIFT;

    // Clamp to the signed 16-bit range and flag any sample that had to be clamped.
    always_comb begin
        sample_out = shr[OUT_W-1:0];
        clamped    = 1'b0;
        if (shr > MAX_S) begin
            sample_out = MAX_S[OUT_W-1:0];
            clamped    = 1'b1;
        end else if (shr < MIN_S) begin
            sample_out = MIN_S[OUT_W-1:0];
            clamped    = 1'b1;
        end
    end

endmodule

// File: rtl/fir3_out_serializer.sv
// Captures 3-lane FIR blocks, rounds/saturates them, queues whole blocks and streams lane 0,1,2.
// Latency: start to first out_valid is 2 cycles when the block queue is empty.
// Backpressure: out_ready low holds out_data/out_valid; a block arriving while the queue is full is dropped and flagged.
module fir3_out_serializer
    import fir3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SHIFT = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [31:0]           y_in0,
    input  logic signed [31:0]           y_in1,
    input  logic signed [31:0]           y_in2,
    output logic signed [15:0]           out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         sat,
    input  logic                         clr_flags
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    acc_t                 y_lane [LANES];
    block_t               r_blk;
    logic [LANES-1:0]     clamp;

    block_t               mem [DEPTH];
    logic                 start_d;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [1:0]           lane;

    logic                 hs;
    logic                 pop;
    logic                 full;
    logic                 wr;
    logic                 drop;

    assign y_lane[0] = y_in0;
    assign y_lane[1] = y_in1;
    assign y_lane[2] = y_in2;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fir3_round_sat #(.SHIFT(SHIFT)) u_round_sat (
            .acc_in     (y_lane[i]),
            .sample_out (r_blk[i]),
            .clamped    (clamp[i])
        );
    end

    // The final pop of a block frees its slot before the same-cycle capture is judged.
    assign hs   = out_valid & out_ready;
    assign pop  = hs & (lane == 2'd2);
    assign full = (level == LVL_W'(DEPTH)) & ~pop;
    assign wr   = start_d & ~full;
    assign drop = start_d & full;

    // Output comes straight from registered storage, so out_ready never reaches out_valid.
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr][lane] : '0;

    // Block storage: written in place, contents only meaningful where level says so.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= r_blk;
        end
    end

    // Capture strobe, pointers, lane counter and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lane    <= 2'd0;
            level   <= '0;
        end else begin
            start_d <= start;
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (hs) begin
                if (lane == 2'd2) begin
                    lane   <= 2'd0;
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end else begin
                    lane <= lane + 2'd1;
                end
            end
            if (wr && !pop) begin
                level <= level + LVL_W'(1);
            end else if (!wr && pop) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Sticky status flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            sat      <= 1'b0;
        end else if (clr_flags) begin
            overflow <= 1'b0;
            sat      <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (start_d && (|clamp)) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir3_out_serializer.sv
// Self-checking bench for fir3_out_serializer against a block-queue reference model.
// Latency: model expects first sample 2 cycles after start into an empty queue.
// Backpressure: random and directed out_ready stalls, overflow and same-edge pop/capture.
module tb_fir3_out_serializer;

    localparam int DEPTH = 4;
    localparam int SHIFT = 15;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [31:0] y_in0;
    logic signed [31:0] y_in1;
    logic signed [31:0] y_in2;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         level;
    logic               overflow;
    logic               sat;
    logic               clr_flags;

    fir3_out_serializer #(.DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .y_in0     (y_in0),
        .y_in1     (y_in1),
        .y_in2     (y_in2),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .sat       (sat),
        .clr_flags (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: queue of whole blocks still (partly) owed to the sink.
    typedef int blk_t [3];
    blk_t mq[$];
    int   m_lane;
    bit   m_sd;
    bit   m_ovf;
    bit   m_sat;

    int checks = 0;
    int errors = 0;

    // Round half up then clamp, from plain integer arithmetic with 32-bit wrap of the sum.
    function automatic int ref_rs(input int y, output bit c);
        longint s, d, q;
        s = longint'(y) + (longint'(1) << (SHIFT - 1));
        if (s > 64'sh7FFF_FFFF) s = s - 64'sh1_0000_0000;
        d = longint'(1) << SHIFT;
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        c = 1'b0;
        if (q > 32767) begin
            q = 32767;
            c = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            c = 1'b1;
        end
        return int'(q);
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(0, 4))
            0: return int'($urandom);
            1: return int'($urandom_range(0, 2000000)) - 1000000;
            2: return 1073725440 + int'($urandom_range(0, 65536)) - 32768;
            3: return -1073758208 + int'($urandom_range(0, 65536)) - 32768;
            default: return 32'sh7FFF_FFFF - int'($urandom_range(0, 40000));
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, (mq.size() != 0));
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("sat", sat, m_sat);
        if (mq.size() != 0) chk("out_data", out_data, mq[0][m_lane]);
    endtask

    task automatic set_y(input int a, input int b, input int c);
        y_in0 = a;
        y_in1 = b;
        y_in2 = c;
    endtask

    task automatic rnd_y();
        set_y(rnd_val(), rnd_val(), rnd_val());
    endtask

    // One clock: predict the edge from pre-edge inputs, then compare on the falling edge.
    task automatic step();
        bit   hs, pop, cap, c0, c1, c2;
        blk_t nb;
        hs  = (mq.size() != 0) && out_ready;
        pop = hs && (m_lane == 2);
        cap = m_sd;
        c0 = 0; c1 = 0; c2 = 0;
        if (cap) begin
            nb[0] = ref_rs(y_in0, c0);
            nb[1] = ref_rs(y_in1, c1);
            nb[2] = ref_rs(y_in2, c2);
        end
        @(posedge clk);
        if (cap) begin
            if (mq.size() == DEPTH && !pop) m_ovf = 1'b1;
            else mq.push_back(nb);
            if (c0 || c1 || c2) m_sat = 1'b1;
        end
        if (clr_flags) begin
            m_ovf = 1'b0;
            m_sat = 1'b0;
        end
        if (hs) begin
            if (pop) begin
                void'(mq.pop_front());
                m_lane = 0;
            end else begin
                m_lane++;
            end
        end
        m_sd = start;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        #1;
        mq.delete();
        m_lane = 0;
        m_sd   = 1'b0;
        m_ovf  = 1'b0;
        m_sat  = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sat", sat, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        set_y(0, 0, 0);
        @(negedge clk);
        do_reset();

        // Single block with one saturating lane, plus 2-cycle latency.
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        set_y(49152, -16384, 32'sh4000_0000);
        chk("lat_k1_valid", out_valid, 0);
        step();
        chk("lat_k2_valid", out_valid, 1);
        chk("blk1_s0", out_data, 2);
        step();
        chk("blk1_s1", out_data, 0);
        step();
        chk("blk1_s2", out_data, 32767);
        chk("blk1_sat", sat, 1);
        step();

        // Rounding edges, half rounds up, no saturation.
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_sat", sat, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        set_y(16383, 16384, -16385);
        step();
        chk("rnd_s0", out_data, 0);
        step();
        chk("rnd_s1", out_data, 1);
        step();
        chk("rnd_s2", out_data, -1);
        chk("rnd_sat", sat, 0);
        step();

        // Five-cycle stall in the middle of a block.
        start = 1'b1;
        step();
        start = 1'b0;
        set_y(100000, 200000, -300000);
        step();
        chk("bp_s0", out_data, 3);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", out_data, 6);
        end
        out_ready = 1'b1;
        step();
        chk("bp_s2", out_data, -9);
        step();
        chk("bp_empty", level, 0);

        // Overflow: five blocks into a four-deep queue with the sink stalled.
        out_ready = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rnd_y();
            step();
        end
        start = 1'b0;
        rnd_y();
        step();
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("ovf_drained", level, 0);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Capture on the same edge as the final pop of a block, queue full.
        out_ready = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd_y();
            step();
        end
        start = 1'b0;
        rnd_y();
        step();
        chk("sim_full", level, 4);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b1;
        rnd_y();
        step();
        chk("sim_level", level, 4);
        chk("sim_ovf", overflow, 0);
        for (int i = 0; i < 12; i++) step();
        chk("sim_drained", level, 0);

        // Reset while lane 1 of a block is on the output.
        start = 1'b1;
        step();
        start = 1'b0;
        rnd_y();
        step();
        step();
        @(negedge clk);
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        set_y(163840, 0, 0);
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_s0", out_data, 5);
        for (int i = 0; i < 3; i++) step();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            start     = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0) || (n % 400 > 300);
            if (n % 400 < 60) out_ready = ($urandom_range(0, 4) == 0);
            clr_flags = ($urandom_range(0, 49) == 0);
            rnd_y();
            step();
        end
        start     = 1'b0;
        clr_flags = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH + 3; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
